stream_sum: RTL and testbench

STREAM_SUM -- requirements
Module: stream_sum

---
 rtl/stream_sum_pkg.sv | 11 +
 rtl/stream_sum_if.sv | 31 +++
 rtl/stream_sum.sv | 98 +++++++++
 tb/tb_stream_sum.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/stream_sum_pkg.sv
// Shared types and defaults for the stream_sum accumulator.
package stream_sum_pkg;
  localparam int unsigned WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    COLLECT = 2'd2,
    RESULT  = 2'd3
  } state_e;
endpackage

// File: rtl/stream_sum_if.sv
// Host-side and upstream-generator signal bundle around stream_sum.
interface stream_sum_if
  import stream_sum_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             start;
  logic [WIDTH-1:0] n;
  logic             ready;
  logic             valid;
  logic             done;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic             ovf;
  logic [WIDTH-1:0] up_n;
  logic             up_start;
  logic             up_ready;
  logic             up_valid;
  logic             up_done;
  logic [WIDTH-1:0] up_data;

  // master = host + generator side, slave = the accumulator
  modport master (
    output start, n, ready, up_valid, up_done, up_data,
    input  valid, done, out0, out1, ovf, up_n, up_start, up_ready
  );
  modport slave (
    input  start, n, ready, up_valid, up_done, up_data,
    output valid, done, out0, out1, ovf, up_n, up_start, up_ready
  );
endinterface

// File: rtl/stream_sum.sv
// Launches an upstream generator, sums its data beats until a terminator,
// then holds the sum/count/overflow result until the host accepts it.
module stream_sum
  import stream_sum_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             __clock,
  input  logic             __reset,
  input  logic             __start,
  input  logic [WIDTH-1:0] n,
  input  logic             __ready,
  output logic             __valid,
  output logic             __done,
  output logic [WIDTH-1:0] __output_0,
  output logic [WIDTH-1:0] __output_1,
  output logic             __overflow,
  output logic [WIDTH-1:0] up_n,
  output logic             up_start,
  output logic             up_ready,
  input  logic             up_valid,
  input  logic             up_done,
  input  logic [WIDTH-1:0] up_output_0
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] up_n_q, up_n_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   add;
  logic             accept;

  assign accept = (state_q == COLLECT) && up_valid;
  assign add    = {1'b0, sum_q} + {1'b0, up_output_0};

  always_ff @(posedge __clock or posedge __reset) begin
    if (__reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (__start) state_d = LAUNCH;
      LAUNCH:  state_d = COLLECT;
      COLLECT: if (accept && up_done) state_d = RESULT;
      RESULT:  if (__ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every host-facing output is a decode of flops only, so up_* never
  // reaches them combinationally.
  always_comb begin
    up_start   = (state_q == LAUNCH);
    up_ready   = (state_q == COLLECT);
    __valid    = (state_q == RESULT);
    __done     = (state_q == RESULT);
    __output_0 = sum_q;
    __output_1 = cnt_q;
    __overflow = ovf_q;
    up_n       = up_n_q;
  end

  always_comb begin
    up_n_d = up_n_q;
    sum_d  = sum_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (state_q == IDLE && __start) begin
      up_n_d = n;
      sum_d  = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end else if (accept && !up_done) begin
      // terminator data is ignored; only real beats accumulate
      sum_d = add[WIDTH-1:0];
      ovf_d = ovf_q | add[WIDTH];
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge __clock or posedge __reset) begin
    if (__reset) begin
      up_n_q <= '0;
      sum_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      up_n_q <= up_n_d;
      sum_q  <= sum_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_stream_sum.sv
// Scoreboard bench for stream_sum: a scripted upstream generator feeds beats,
// a reference sum/count/overflow is queued per run and compared on the result.
module tb_stream_sum;
  import stream_sum_pkg::*;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stream_sum_if #(.WIDTH(W)) bus();

  stream_sum #(.WIDTH(W)) dut (
    .__clock     (clk),
    .__reset     (rst),
    .__start     (bus.start),
    .n           (bus.n),
    .__ready     (bus.ready),
    .__valid     (bus.valid),
    .__done      (bus.done),
    .__output_0  (bus.out0),
    .__output_1  (bus.out1),
    .__overflow  (bus.ovf),
    .up_n        (bus.up_n),
    .up_start    (bus.up_start),
    .up_ready    (bus.up_ready),
    .up_valid    (bus.up_valid),
    .up_done     (bus.up_done),
    .up_output_0 (bus.up_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           v;
    bit           d;
    logic [W-1:0] data;
  } item_t;

  typedef struct {
    logic [W-1:0] sum;
    logic [W-1:0] cnt;
    logic         ovf;
    logic [W-1:0] n;
  } exp_t;

  item_t items[$];
  exp_t  sb[$];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_item(input bit v, input bit d, input logic [W-1:0] data);
    item_t it;
    it.v = v; it.d = d; it.data = data;
    items.push_back(it);
  endtask

  function automatic exp_t model(input logic [W-1:0] nv);
    exp_t         e;
    logic [W:0]   a;
    e.sum = '0; e.cnt = '0; e.ovf = 1'b0; e.n = nv;
    foreach (items[i]) begin
      if (items[i].v) begin
        if (items[i].d) break;
        a     = {1'b0, e.sum} + {1'b0, items[i].data};
        e.sum = a[W-1:0];
        e.ovf = e.ovf | a[W];
        e.cnt = e.cnt + 1;
      end
    end
    return e;
  endfunction

  task automatic launch(input logic [W-1:0] nv);
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = nv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.n     = ~nv;
    chk("up_start", bus.up_start, 1);
    chk("up_n", bus.up_n, nv);
  endtask

  // Presents each scripted item; valid items are held until the DUT takes them.
  task automatic feed();
    bit acc;
    int tries;
    foreach (items[i]) begin
      bus.up_valid = items[i].v;
      bus.up_done  = items[i].d;
      bus.up_data  = items[i].data;
      if (!items[i].v) begin
        @(posedge clk); #1;
      end else begin
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 20) begin
          @(negedge clk);
          acc = bus.up_ready;
          chk("early_valid", bus.valid, 0);
          @(posedge clk); #1;
          tries++;
        end
        if (!acc) chk("feed_tmo", acc, 1);
      end
    end
    bus.up_valid = 1'b0;
    bus.up_done  = 1'b0;
    bus.up_data  = 32'hDEAD_BEEF;
  endtask

  task automatic finish_run(input int hold);
    exp_t e;
    e = sb.pop_front();
    chk("valid_lat", bus.valid, 1);
    chk("done", bus.done, 1);
    chk("sum", bus.out0, e.sum);
    chk("cnt", bus.out1, e.cnt);
    chk("ovf", bus.ovf, e.ovf);
    chk("up_n_hold", bus.up_n, e.n);
    for (int i = 0; i < hold; i++) begin
      bus.start = (i == 2);
      @(posedge clk); #1;
      chk("hold_valid", bus.valid, 1);
      chk("hold_sum", bus.out0, e.sum);
      chk("hold_cnt", bus.out1, e.cnt);
      chk("hold_upstart", bus.up_start, 0);
    end
    bus.start = 1'b0;
    bus.ready = 1'b1;
    @(posedge clk); #1;
    bus.ready = 1'b0;
    chk("valid_clr", bus.valid, 0);
    chk("done_clr", bus.done, 0);
  endtask

  task automatic do_run(input logic [W-1:0] nv, input int hold);
    sb.push_back(model(nv));
    launch(nv);
    feed();
    finish_run(hold);
    items.delete();
  endtask

  task automatic fib_items();
    add_item(1, 0, 1); add_item(1, 0, 1); add_item(1, 0, 3); add_item(1, 0, 5);
    add_item(1, 1, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, bus.valid, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_out0"}, bus.out0, 0);
    chk({tag, "_out1"}, bus.out1, 0);
    chk({tag, "_ovf"}, bus.ovf, 0);
    chk({tag, "_up_n"}, bus.up_n, 0);
    chk({tag, "_up_start"}, bus.up_start, 0);
    chk({tag, "_up_ready"}, bus.up_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.n = '0; bus.ready = 0;
    bus.up_valid = 0; bus.up_done = 0; bus.up_data = '0;
    #12;
    chk_all_zero("rst");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("idle");

    // odd Fibonacci terms below 10, then an immediate back-to-back empty run
    fib_items();
    do_run(10, 0);
    add_item(1, 1, 0);
    do_run(0, 0);

    // sum carry-out wraps and sets the sticky flag
    add_item(1, 0, 32'hFFFF_FFFF); add_item(1, 0, 2); add_item(1, 1, 0);
    do_run(32'd99, 0);

    // host stalls five cycles, start pulse during RESULT must not relaunch
    add_item(1, 0, 4); add_item(1, 0, 6); add_item(1, 1, 32'h55);
    do_run(32'd7, 5);
    repeat (2) begin
      @(posedge clk); #1;
      chk("no_relaunch", bus.up_start, 0);
      chk("idle_rdy", bus.up_ready, 0);
    end

    // gaps in up_valid: idle data must be ignored
    add_item(1, 0, 7); add_item(0, 0, 100); add_item(0, 0, 200); add_item(1, 0, 9);
    add_item(1, 1, 0);
    do_run(32'd3, 0);

    // reset mid-COLLECT after two beats, then a clean rerun
    add_item(1, 0, 1); add_item(1, 0, 1);
    launch(10);
    feed();
    items.delete();
    chk("mid_cnt", bus.out1, 2);
    chk("mid_sum", bus.out0, 2);
    bus.up_valid = 1'b1; bus.up_data = 32'd3;
    #2 rst = 1'b1;
    #1 chk_all_zero("async");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_rdy", bus.up_ready, 0);
    chk("post_rst_cnt", bus.out1, 0);
    bus.up_valid = 1'b0;
    fib_items();
    do_run(10, 0);

    // random beats with random gaps
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) add_item(0, 0, $urandom);
      add_item(1, 0, $urandom);
    end
    add_item(1, 1, $urandom);
    do_run($urandom, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
